restoring_divider: RTL and testbench

Iterative unsigned restoring divider: quotient = dividend / divisor, remainder = dividend % divisor.
- One quotient bit per clock, via shift-and-subtract.
- This is the subtract/inverse side of the team's adder datapath: it undoes accumulation.
- Sits beside the arithmetic blocks as a multi-cycle unit with a start/done handshake, for operations too costly to do combinationally.

---
 rtl/restoring_divider_if.sv | 43 ++++
 rtl/restoring_divider.sv | 156 +++++++++++++++
 tb/tb_restoring_divider.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/restoring_divider_if.sv
//==============================================================================
// Module   : restoring_divider_if
// Brief    : Start/done handshake and operand/result bundle for restoring_divider
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface restoring_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/restoring_divider.sv
//==============================================================================
// Module   : restoring_divider
// Brief    : Iterative restoring divider, one quotient bit per clock.
//            Define DIV_SIGNED_EN for two's-complement operands.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module restoring_divider #(
    parameter int WIDTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    restoring_divider_if.slave   bus
);

    localparam int c_cnt_w = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_cnt_w-1:0] r_count;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_dbz;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_dd_mag;
    logic [WIDTH-1:0]   w_dv_mag;
    logic [WIDTH-1:0]   w_quot_fin;
    logic [WIDTH-1:0]   w_rem_fin;

    assign w_accept   = (r_state == S_IDLE) && bus.start;
    assign w_div_zero = (bus.divisor == '0);
    assign w_last     = (r_count == c_cnt_w'(1));

    // The held remainder is always below the divisor, so its top bit is zero
    // and only WIDTH bits need storing; the shifted value carries the extra bit.
    assign w_shift   = {r_rem, r_q[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_divisor};
    assign w_rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_q_nxt   = {r_q[WIDTH-2:0], ~w_trial[WIDTH]};

`ifdef DIV_SIGNED_EN
    logic w_dd_neg;
    logic w_dv_neg;
    logic r_q_neg;
    logic r_r_neg;

    assign w_dd_neg = bus.dividend[WIDTH-1];
    assign w_dv_neg = bus.divisor[WIDTH-1];
    // The most-negative value maps onto itself, which reads correctly as an
    // unsigned magnitude, so MIN / -1 naturally wraps back to MIN.
    assign w_dd_mag = w_dd_neg ? -bus.dividend : bus.dividend;
    assign w_dv_mag = w_dv_neg ? -bus.divisor  : bus.divisor;
    assign w_quot_fin = r_q_neg ? -w_q_nxt   : w_q_nxt;
    assign w_rem_fin  = r_r_neg ? -w_rem_nxt : w_rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
        end else if (w_accept) begin
            r_q_neg <= w_dd_neg ^ w_dv_neg;
            r_r_neg <= w_dd_neg;
        end
    end
`else
    assign w_dd_mag   = bus.dividend;
    assign w_dv_mag   = bus.divisor;
    assign w_quot_fin = w_q_nxt;
    assign w_rem_fin  = w_rem_nxt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quotient  <= '1;
                r_remainder <= bus.dividend;
                r_dbz       <= 1'b1;
            end else begin
                r_count   <= c_cnt_w'(WIDTH);
                r_rem     <= '0;
                r_q       <= w_dd_mag;
                r_divisor <= w_dv_mag;
                r_dbz     <= 1'b0;
            end
        end else if (r_state == S_RUN) begin
            r_rem   <= w_rem_nxt;
            r_q     <= w_q_nxt;
            r_count <= r_count - c_cnt_w'(1);
            if (w_last) begin
                r_quotient  <= w_quot_fin;
                r_remainder <= w_rem_fin;
            end
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
//==============================================================================
// Module   : tb_restoring_divider
// Brief    : Scoreboard bench for restoring_divider (WIDTH=4, directed vectors)
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_restoring_divider;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
        string        name;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    restoring_divider_if #(.WIDTH(W)) dif ();

    restoring_divider #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && dif.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, ".quotient"},  dif.quotient,    e.q);
                check({e.name, ".remainder"}, dif.remainder,   e.r);
                check({e.name, ".dbz"},       dif.div_by_zero, e.dbz);
                check({e.name, ".latency"},   cyc,             e.due);
            end
        end
    end

    // Drive one request for a single cycle, then scramble the operands.
    task automatic issue(input string name, input logic [W-1:0] dd, input logic [W-1:0] dv,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = dd;
        dif.divisor  = dv;
        e.q    = q;
        e.r    = r;
        e.dbz  = dbz;
        e.due  = cyc + ((dv == '0) ? 1 : W + 1);
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = ~dd;
        dif.divisor  = ~dv;
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (!dif.busy && sb.size() == 0) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s.timeout: got busy=%0d pending=%0d, expected idle", name, dif.busy, sb.size());
        sb.delete();
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (dif.done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s.done_timeout: got done=0, expected 1", name);
    endtask

    initial begin
        rst          = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset.quotient",  dif.quotient,    0);
        check("reset.remainder", dif.remainder,   0);
        check("reset.dbz",       dif.div_by_zero, 0);
        check("reset.busy",      dif.busy,        0);
        check("reset.done",      dif.done,        0);
        rst = 1'b0;

`ifndef DIV_SIGNED_EN
        // 13/3 with busy profile across the run and done cycles
        issue("d13_3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0);
        #2;
        check("d13_3.busy_t1", dif.busy, 1);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            #2;
            check($sformatf("d13_3.busy_t%0d", i), dif.busy, 1);
        end
        @(negedge clk);
        #2;
        check("d13_3.busy_after", dif.busy, 0);
        wait_idle("d13_3");

        issue("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
        wait_idle("d7_0");
        issue("d6_2", 4'd6, 4'd2, 4'd3, 4'd0, 1'b0);
        #2;
        check("d6_2.dbz_cleared", dif.div_by_zero, 0);
        check("d6_2.q_held",      dif.quotient,    15);
        wait_idle("d6_2");

        issue("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
        wait_idle("d15_1");
        issue("d2_5", 4'd2, 4'd5, 4'd0, 4'd2, 1'b0);
        wait_idle("d2_5");
        issue("d0_9", 4'd0, 4'd9, 4'd0, 4'd0, 1'b0);
        wait_idle("d0_9");

        // A start during RUN is dropped; a start right after done is taken.
        issue("d9_4", 4'd9, 4'd4, 4'd2, 4'd1, 1'b0);
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 4'd15;
        dif.divisor  = 4'd15;
        @(negedge clk);
        dif.start = 1'b0;
        wait_done("d9_4");
        issue("b2b_15_15", 4'd15, 4'd15, 4'd1, 4'd0, 1'b0);
        wait_idle("b2b_15_15");

        // Reset during RUN aborts without a done pulse.
        issue("abort_14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort.quotient",  dif.quotient,    0);
        check("abort.remainder", dif.remainder,   0);
        check("abort.busy",      dif.busy,        0);
        check("abort.done",      dif.done,        0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        issue("d14_3", 4'd14, 4'd3, 4'd4, 4'd2, 1'b0);
        wait_idle("d14_3");
`else
        issue("s_m7_2",  4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0);
        wait_idle("s_m7_2");
        issue("s_7_m2",  4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0);
        wait_idle("s_7_m2");
        issue("s_m8_m1", 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0);
        wait_idle("s_m8_m1");
        issue("s_6_3",   4'b0110, 4'b0011, 4'b0010, 4'b0000, 1'b0);
        wait_idle("s_6_3");
        issue("s_m3_0",  4'b1101, 4'b0000, 4'b1111, 4'b1101, 1'b1);
        wait_idle("s_m3_0");
        issue("s_m6_m4", 4'b1010, 4'b1100, 4'b0001, 4'b1110, 1'b0);
        wait_idle("s_m6_m4");
`endif

        repeat (8) @(negedge clk);
        check("scoreboard.empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
